// File: rtl/vga_pixel_pipe.sv
// Pixel pipe between the VGA timing generator and the frame ROM: incremental
// address generation, ROM latency compensation, registered DAC outputs.
module vga_pixel_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic [9:0]        x_coordinate,
  input  logic [9:0]        y_coordinate,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              synch_in,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [23:0]       rom_q,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_n_out,
  output logic              sync_n_out,
  output logic              frame_done
);
  localparam int                D         = ROM_LAT + 2;
  localparam logic [9:0]        X_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]        Y_LIM     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic sync_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = sync_t'(4'b1101);

  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] line_next;
  logic [9:0]        prev_y;
  logic              pix_valid;
  logic              pix_last;
  logic [D-1:1]      vld_pipe;
  logic [D-1:1]      last_pipe;
  sync_t [D-1:0]     sync_pipe;
  logic [23:0]       rgb;

  // Row base advances by one line on each new active row; the next-value is
  // used directly so the first pixel of a row already sees the new base.
  always_comb begin
    line_next = line_base;
    if (y_coordinate == '0)
      line_next = '0;
    else if ((y_coordinate != prev_y) && (y_coordinate < Y_LIM))
      line_next = line_base + LINE_STEP;
  end

  assign pix_valid = video_on_in && (x_coordinate < X_LIM) && (y_coordinate < Y_LIM);
  assign pix_last  = pix_valid && (x_coordinate == X_LIM - 10'd1) &&
                     (y_coordinate == Y_LIM - 10'd1);

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      line_base   <= '0;
      prev_y      <= '0;
      rom_address <= '0;
    end else begin
      line_base <= line_next;
      prev_y    <= y_coordinate;
      if (pix_valid)
        rom_address <= line_next + ADDR_W'(x_coordinate);
    end
  end

  // Valid/last need D-1 stages to gate the RGB register; sync bits need all D.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      sync_pipe <= {D{SYNC_IDLE}};
    end else begin
      vld_pipe  <= {vld_pipe[D-2:1], pix_valid};
      last_pipe <= {last_pipe[D-2:1], pix_last};
      sync_pipe <= {sync_pipe[D-2:0],
                    sync_t'({hsync_in, vsync_in, video_on_in, synch_in})};
    end
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      rgb        <= '0;
      frame_done <= 1'b0;
    end else begin
      rgb        <= vld_pipe[D-1] ? rom_q : 24'h0;
      frame_done <= last_pipe[D-1];
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;
  assign hsync_out   = sync_pipe[D-1].hsync;
  assign vsync_out   = sync_pipe[D-1].vsync;
  assign blank_n_out = sync_pipe[D-1].blank_n;
  assign sync_n_out  = sync_pipe[D-1].sync_n;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: two instances (ROM_LAT=1 and 3) share one
// shortened 800x525 raster; each has its own ROM model.
module tb_vga_pixel_pipe;
  logic        clk_25 = 1'b0;
  logic        n_rst;
  logic [9:0]  x_coordinate, y_coordinate;
  logic        video_on_in, hsync_in, vsync_in, synch_in;
  logic        rom_ff;

  logic [18:0] addr1, addr3;
  logic [23:0] q1r, p3a, p3b, q3r, rom_q1, rom_q3;
  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, bn1, sn1, fd1, hs3, vs3, bn3, sn3, fd3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] hx [16];
  logic [9:0] hy [16];
  bit hvo [16], hhs [16], hvs [16], hlast [16];

  int frame_q [$];

  always #20 clk_25 = ~clk_25;

  vga_pixel_pipe #(.ROM_LAT(1)) u_dut1 (
    .clk_25(clk_25), .n_rst(n_rst), .x_coordinate(x_coordinate), .y_coordinate(y_coordinate),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .synch_in(synch_in),
    .rom_address(addr1), .rom_q(rom_q1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync_out(hs1), .vsync_out(vs1), .blank_n_out(bn1), .sync_n_out(sn1), .frame_done(fd1));

  vga_pixel_pipe #(.ROM_LAT(3)) u_dut3 (
    .clk_25(clk_25), .n_rst(n_rst), .x_coordinate(x_coordinate), .y_coordinate(y_coordinate),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .synch_in(synch_in),
    .rom_address(addr3), .rom_q(rom_q3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .hsync_out(hs3), .vsync_out(vs3), .blank_n_out(bn3), .sync_n_out(sn3), .frame_done(fd3));

  function automatic logic [23:0] rom_f(input logic [18:0] a);
    return {a[7:0], a[15:8], 5'h0, a[18:16]};
  endfunction

  always @(posedge clk_25) q1r <= rom_f(addr1);
  always @(posedge clk_25) begin
    p3a <= rom_f(addr3);
    p3b <= p3a;
    q3r <= p3b;
  end
  assign rom_q1 = rom_ff ? 24'hFFFFFF : q1r;
  assign rom_q3 = rom_ff ? 24'hFFFFFF : q3r;

  // Expected pixel for the input driven d cycles ago.
  function automatic logic [23:0] exp_rgb(input int d);
    int k;
    k = (cyc - d) & 15;
    if (!hvo[k]) return 24'h0;
    return rom_f(19'(int'(hy[k]) * 640 + int'(hx[k])));
  endfunction

  function automatic int hidx(input int d);
    return (cyc - d) & 15;
  endfunction

  // Rows 0-2, 200 and 479 are full length; other rows are shortened to keep
  // the run small while every row transition still occurs.
  function automatic void build_frame();
    for (int y = 0; y < 525; y++) begin
      if (y <= 2 || y == 200 || y == 479) begin
        for (int x = 0; x < 800; x++) frame_q.push_back((y << 16) | x);
      end else if (y < 480) begin
        frame_q.push_back((y << 16) | 0);
        frame_q.push_back((y << 16) | 639);
        frame_q.push_back((y << 16) | 640);
        frame_q.push_back((y << 16) | 700);
      end else begin
        frame_q.push_back((y << 16) | 0);
        frame_q.push_back((y << 16) | 700);
      end
    end
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) begin
      hx[i] = '0; hy[i] = '0; hvo[i] = 0; hhs[i] = 1; hvs[i] = 1; hlast[i] = 0;
    end
  endtask

  // Called at a falling edge; applies one raster position for the next rising edge.
  task automatic drive(input int x, input int y);
    int k;
    bit vo, hs, vs;
    vo = (x < 640) && (y < 480);
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
    x_coordinate = 10'(x);
    y_coordinate = 10'(y);
    video_on_in  = vo;
    hsync_in     = hs;
    vsync_in     = vs;
    synch_in     = hs & vs;
    k = cyc & 15;
    if (n_rst) begin
      hx[k] = 10'(x); hy[k] = 10'(y); hvo[k] = vo; hhs[k] = hs; hvs[k] = vs;
      hlast[k] = vo && x == 639 && y == 479;
    end else begin
      hx[k] = '0; hy[k] = '0; hvo[k] = 0; hhs[k] = 1; hvs[k] = 1; hlast[k] = 0;
    end
    @(negedge clk_25);
    cyc++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    rom_ff = 1'b0;
    repeat (4) begin
      x_coordinate = 10'($urandom); y_coordinate = 10'($urandom);
      video_on_in = 1'($urandom); hsync_in = 1'($urandom);
      vsync_in = 1'($urandom); synch_in = 1'($urandom);
      @(negedge clk_25);
    end
    total += 6;
    if (addr1 !== 19'd0) begin bad++; $display("FAIL reset_addr1 got=%0d exp=0", addr1); end
    if (addr3 !== 19'd0) begin bad++; $display("FAIL reset_addr3 got=%0d exp=0", addr3); end
    if ({r1, g1, b1} !== 24'h0) begin bad++; $display("FAIL reset_rgb1 got=%h exp=0", {r1, g1, b1}); end
    if ({r3, g3, b3} !== 24'h0) begin bad++; $display("FAIL reset_rgb3 got=%h exp=0", {r3, g3, b3}); end
    if ({hs1, vs1, sn1, bn1, fd1} !== 5'b11100) begin
      bad++; $display("FAIL reset_ctl1 got=%b exp=11100", {hs1, vs1, sn1, bn1, fd1});
    end
    if ({hs3, vs3, sn3, bn3, fd3} !== 5'b11100) begin
      bad++; $display("FAIL reset_ctl3 got=%b exp=11100", {hs3, vs3, sn3, bn3, fd3});
    end
    clear_hist();
    cyc = 0;
    n_rst = 1'b1;
  endtask

  task automatic test_address();
    int x, y, ex;
    foreach (frame_q[i]) begin
      x = frame_q[i] & 16'hFFFF;
      y = frame_q[i] >> 16;
      drive(x, y);
      ex = -1;
      if (x == 0 && y == 0) ex = 0;
      else if (x == 639 && y == 0) ex = 639;
      else if (x == 0 && y == 1) ex = 640;
      else if (x == 5 && y == 2) ex = 1285;
      else if (x == 639 && y == 479) ex = 307199;
      if (ex >= 0) begin
        total += 2;
        if (addr1 !== 19'(ex)) begin bad++; $display("FAIL addr1 (%0d,%0d) got=%0d exp=%0d", x, y, addr1, ex); end
        if (addr3 !== 19'(ex)) begin bad++; $display("FAIL addr3 (%0d,%0d) got=%0d exp=%0d", x, y, addr3, ex); end
      end
    end
  endtask

  task automatic test_latency();
    logic [23:0] e1, e3;
    foreach (frame_q[i]) begin
      drive(frame_q[i] & 16'hFFFF, frame_q[i] >> 16);
      e1 = exp_rgb(3);
      e3 = exp_rgb(5);
      total += 7;
      if ({r1, g1, b1} !== e1) begin bad++; $display("FAIL lat1_rgb cyc=%0d got=%h exp=%h", cyc, {r1, g1, b1}, e1); end
      if (hs1 !== hhs[hidx(3)]) begin bad++; $display("FAIL lat1_hsync cyc=%0d got=%b exp=%b", cyc, hs1, hhs[hidx(3)]); end
      if (fd1 !== hlast[hidx(3)]) begin bad++; $display("FAIL lat1_done cyc=%0d got=%b exp=%b", cyc, fd1, hlast[hidx(3)]); end
      if ({r3, g3, b3} !== e3) begin bad++; $display("FAIL lat3_rgb cyc=%0d got=%h exp=%h", cyc, {r3, g3, b3}, e3); end
      if (bn3 !== hvo[hidx(5)]) begin bad++; $display("FAIL lat3_blank cyc=%0d got=%b exp=%b", cyc, bn3, hvo[hidx(5)]); end
      if (vs3 !== hvs[hidx(5)]) begin bad++; $display("FAIL lat3_vsync cyc=%0d got=%b exp=%b", cyc, vs3, hvs[hidx(5)]); end
      if (fd3 !== hlast[hidx(5)]) begin bad++; $display("FAIL lat3_done cyc=%0d got=%b exp=%b", cyc, fd3, hlast[hidx(5)]); end
    end
  endtask

  task automatic test_blanking();
    logic [23:0] e1, e3;
    rom_ff = 1'b1;
    for (int x = 0; x < 800; x++) begin
      drive(x, 0);
      e1 = hvo[hidx(3)] ? 24'hFFFFFF : 24'h0;
      e3 = hvo[hidx(5)] ? 24'hFFFFFF : 24'h0;
      total += 2;
      if ({r1, g1, b1} !== e1) begin bad++; $display("FAIL blank_rgb1 x=%0d got=%h exp=%h", x, {r1, g1, b1}, e1); end
      if ({r3, g3, b3} !== e3) begin bad++; $display("FAIL blank_rgb3 x=%0d got=%h exp=%h", x, {r3, g3, b3}, e3); end
      if (x >= 640) begin
        total += 2;
        if (addr1 !== 19'd639) begin bad++; $display("FAIL blank_hold1 x=%0d got=%0d exp=639", x, addr1); end
        if (addr3 !== 19'd639) begin bad++; $display("FAIL blank_hold3 x=%0d got=%0d exp=639", x, addr3); end
      end
    end
    rom_ff = 1'b0;
  endtask

  task automatic test_frame_wrap();
    int klast, n1, n3, x, y;
    klast = -100; n1 = 0; n3 = 0;
    foreach (frame_q[i]) begin
      x = frame_q[i] & 16'hFFFF;
      y = frame_q[i] >> 16;
      if (x == 639 && y == 479) klast = cyc;
      drive(x, y);
      n1 += int'(fd1);
      n3 += int'(fd3);
      total += 2;
      if (fd1 !== (cyc == klast + 3)) begin bad++; $display("FAIL wrap_done1 cyc=%0d got=%b exp=%b", cyc, fd1, cyc == klast + 3); end
      if (fd3 !== (cyc == klast + 5)) begin bad++; $display("FAIL wrap_done3 cyc=%0d got=%b exp=%b", cyc, fd3, cyc == klast + 5); end
    end
    drive(0, 0);
    total += 4;
    if (n1 != 1) begin bad++; $display("FAIL wrap_pulses1 got=%0d exp=1", n1); end
    if (n3 != 1) begin bad++; $display("FAIL wrap_pulses3 got=%0d exp=1", n3); end
    if (addr1 !== 19'd0) begin bad++; $display("FAIL wrap_addr1 got=%0d exp=0", addr1); end
    if (addr3 !== 19'd0) begin bad++; $display("FAIL wrap_addr3 got=%0d exp=0", addr3); end
  endtask

  task automatic test_reset_mid();
    int x, y;
    logic [23:0] e1, e3;
    bit after;
    after = 0;
    foreach (frame_q[i]) begin
      x = frame_q[i] & 16'hFFFF;
      y = frame_q[i] >> 16;
      if (x == 100 && y == 200 && !after) begin
        n_rst = 1'b0;
        repeat (3) drive(100, 200);
        total += 4;
        if ({addr1, r1, g1, b1} !== 43'h0) begin bad++; $display("FAIL mid_data1 got=%h exp=0", {addr1, r1, g1, b1}); end
        if ({addr3, r3, g3, b3} !== 43'h0) begin bad++; $display("FAIL mid_data3 got=%h exp=0", {addr3, r3, g3, b3}); end
        if ({hs1, vs1, sn1, bn1, fd1} !== 5'b11100) begin bad++; $display("FAIL mid_ctl1 got=%b exp=11100", {hs1, vs1, sn1, bn1, fd1}); end
        if ({hs3, vs3, sn3, bn3, fd3} !== 5'b11100) begin bad++; $display("FAIL mid_ctl3 got=%b exp=11100", {hs3, vs3, sn3, bn3, fd3}); end
        n_rst = 1'b1;
        after = 1;
      end else begin
        drive(x, y);
      end
    end
    foreach (frame_q[i]) begin
      x = frame_q[i] & 16'hFFFF;
      y = frame_q[i] >> 16;
      drive(x, y);
      e1 = exp_rgb(3);
      e3 = exp_rgb(5);
      total += 2;
      if ({r1, g1, b1} !== e1) begin bad++; $display("FAIL post_rgb1 cyc=%0d got=%h exp=%h", cyc, {r1, g1, b1}, e1); end
      if ({r3, g3, b3} !== e3) begin bad++; $display("FAIL post_rgb3 cyc=%0d got=%h exp=%h", cyc, {r3, g3, b3}, e3); end
      if ((x == 0 && y == 0) || (x == 5 && y == 2)) begin
        total += 2;
        if (addr1 !== ((y == 0) ? 19'd0 : 19'd1285)) begin bad++; $display("FAIL post_addr1 (%0d,%0d) got=%0d", x, y, addr1); end
        if (addr3 !== ((y == 0) ? 19'd0 : 19'd1285)) begin bad++; $display("FAIL post_addr3 (%0d,%0d) got=%0d", x, y, addr3); end
      end
    end
  endtask

  initial begin
    build_frame();
    test_reset();
    test_address();
    test_latency();
    test_blanking();
    test_frame_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
